// File: rtl/abs_diff_reconstructor.sv
// Rebuilds pixels as ref_pix +/- mag, one residual per handshake, in blocks of BLOCK_PIXELS.
// Define RECON_SATURATE_EN to clamp out-of-range results; otherwise they wrap modulo 2^WIDTH.
module abs_diff_reconstructor #(
    parameter int WIDTH        = 8,
    parameter int BLOCK_PIXELS = 16,
    parameter int CNT_W        = $clog2(BLOCK_PIXELS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ref_pix,
    input  logic [WIDTH-1:0] mag,
    input  logic             sign,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             block_done,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
    // a source holding valid keeps its data stable until that edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_PIXELS - 1);

    if (BLOCK_PIXELS < 2) begin : g_bad_block
        $error("BLOCK_PIXELS must be at least 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_pix_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;
    logic             accept;
    logic             out_xfer;
    logic [WIDTH-1:0] recon;

    assign accept   = in_valid & in_ready;
    assign out_xfer = out_valid_q & out_ready;

`ifdef RECON_SATURATE_EN
    logic [WIDTH:0] sum_w;

    // The extra bit is the carry for an add and the borrow for a subtract.
    always_comb begin
        sum_w = sign ? ({1'b0, ref_pix} - {1'b0, mag})
                     : ({1'b0, ref_pix} + {1'b0, mag});
        if (sum_w[WIDTH]) begin
            recon = sign ? '0 : '1;
        end else begin
            recon = sum_w[WIDTH-1:0];
        end
    end
`else
    always_comb begin
        recon = sign ? (ref_pix - mag) : (ref_pix + mag);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && (cnt_q == LAST_IDX)) state_d = DRAIN;
            DRAIN:   if (out_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == RUN) || (state_q == DRAIN);
        in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
        dbg_state = state_q;
    end

    // Single output register: a new accept may replace a word leaving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pix_q   <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            if (accept) begin
                out_pix_q   <= recon;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if ((state_q == IDLE) && start) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            done_q <= (state_q == DRAIN) && out_xfer;
        end
    end

    assign out_pix    = out_pix_q;
    assign out_valid  = out_valid_q;
    assign pix_cnt    = cnt_q;
    assign block_done = done_q;

endmodule

// File: tb/tb_abs_diff_reconstructor.sv
// Directed bench for abs_diff_reconstructor: hand-computed vectors, scoreboard queue, one summary line.
module tb_abs_diff_reconstructor;

  localparam int WIDTH = 8;
  localparam int BP    = 16;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] ref_pix;
  logic [WIDTH-1:0] mag;
  logic             sign;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_pix;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             block_done;
  logic [CNT_W-1:0] pix_cnt;
  logic [1:0]       dbg_state;

  abs_diff_reconstructor #(
    .WIDTH(WIDTH),
    .BLOCK_PIXELS(BP),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ref_pix(ref_pix),
    .mag(mag),
    .sign(sign),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_pix(out_pix),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .block_done(block_done),
    .pix_cnt(pix_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // vectors: ref, mag, sign and the hand-computed reconstructed pixel
  logic [7:0] ref_tab [16] = '{8'd100, 8'd100, 8'd250, 8'd5, 8'd77, 8'd0, 8'd255, 8'd255,
                               8'd128, 8'd128, 8'd0, 8'd200, 8'd10, 8'd1, 8'd60, 8'd33};
  logic [7:0] mag_tab [16] = '{8'd20, 8'd20, 8'd10, 8'd9, 8'd0, 8'd0, 8'd255, 8'd255,
                               8'd127, 8'd128, 8'd1, 8'd50, 8'd10, 8'd254, 8'd3, 8'd34};
  logic       sgn_tab [16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef RECON_SATURATE_EN
  logic [7:0] exp_tab [16] = '{8'd120, 8'd80, 8'd255, 8'd0, 8'd77, 8'd0, 8'd0, 8'd255,
                               8'd255, 8'd255, 8'd0, 8'd150, 8'd0, 8'd255, 8'd63, 8'd0};
`else
  logic [7:0] exp_tab [16] = '{8'd120, 8'd80, 8'd4, 8'd252, 8'd77, 8'd0, 8'd0, 8'd254,
                               8'd255, 8'd0, 8'd255, 8'd150, 8'd0, 8'd255, 8'd63, 8'd255};
`endif

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_out_pix"}, out_pix, 0);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_in_ready"}, in_ready, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_block_done"}, block_done, 0);
    check_eq({tag, "_pix_cnt"}, pix_cnt, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  // Runs one block; stops early after stop_at accepts when stop_at < BP.
  task automatic run_block(input int stop_at, input int stall_after, input bit check_burst);
    int idx, xfers, dones, cyc, last_xfer_cyc, done_cyc, stall_left, run_len, max_run;
    bit stalled_once, finished, acc, xf;
    logic [WIDTH-1:0] held, exp_v;
    idx = 0; xfers = 0; dones = 0; cyc = 0; last_xfer_cyc = -1; done_cyc = -1;
    stall_left = 0; run_len = 0; max_run = 0; stalled_once = 0; finished = 0;
    held = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_busy", busy, 1);
    check_eq("start_pix_cnt", pix_cnt, 0);
    check_eq("start_state_run", dbg_state, 1);
    while (!finished && cyc < 200) begin
      if (stop_at < BP && idx >= stop_at) break;
      in_valid = (idx < BP);
      ref_pix  = ref_tab[idx % BP];
      mag      = mag_tab[idx % BP];
      sign     = sgn_tab[idx % BP];
      if (stall_after >= 0 && !stalled_once && idx == stall_after) begin
        stall_left   = 3;
        stalled_once = 1'b1;
        held         = out_pix;
      end
      out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_out_valid", out_valid, 1);
        check_eq("stall_hold", out_pix, held);
        stall_left--;
      end
      acc = in_valid & in_ready;
      xf  = out_valid & out_ready;
      if (out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (check_burst && cyc == 1) check_eq("first_latency_valid", out_valid, 1);
      if (dbg_state == 2'd2) check_eq("drain_pix_cnt", pix_cnt, BP);
      if (block_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (xf) begin
        check_eq("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check_eq("out_pix", out_pix, exp_v);
        end
        xfers++;
        last_xfer_cyc = cyc;
      end
      if (acc) begin
        exp_q.push_back(exp_tab[idx]);
        idx++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) finished = 1'b1;
      cyc++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (stop_at >= BP) begin
      check_eq("block_finished", finished, 1);
      check_eq("xfer_count", xfers, BP);
      check_eq("done_pulses", dones, 1);
      check_eq("done_timing", done_cyc, last_xfer_cyc + 1);
      check_eq("queue_empty", exp_q.size(), 0);
      check_eq("end_state_idle", dbg_state, 0);
      check_eq("end_busy", busy, 0);
      if (check_burst) check_eq("burst_len", max_run, BP);
    end else begin
      check_eq("partial_pix_cnt", pix_cnt, stop_at);
      check_eq("partial_out_valid", out_valid, 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ref_pix = '0; mag = '0; sign = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    check_eq("idle_in_ready", in_ready, 0);
    check_eq("idle_state", dbg_state, 0);

    run_block(BP, -1, 1'b1);
    run_block(BP, 4, 1'b0);
    run_block(7, -1, 1'b0);

    rst = 1'b1;
    #1;
    check_reset_values("midblock_rst");
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();

    run_block(BP, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
